nonce_dispatch_ctrl: RTL and testbench

- Search controller for the multi-lane mining datapath.
- Sequences a nonce search across NUM_LANES parallel hash/compare lanes and hands each lane a nonce per round.
- Collects per-lane results, picks the winning nonce, and reports success or exhaustion of the nonce range.
- Sits between the block-input stage and the per-lane nonce/concatenate/hash/compare chains; replaces free-running per-lane nonce generators and the output merge.

---
 rtl/nonce_dispatch_ctrl_if.sv | 34 +++
 rtl/nonce_dispatch_ctrl.sv | 156 +++++++++++++++
 tb/tb_nonce_dispatch_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nonce_dispatch_ctrl_if.sv
// Handshake bundle between the nonce search controller and its
// requester / hash lanes.
interface nonce_dispatch_ctrl_if #(
    parameter int NUM_LANES = 3,
    parameter int NONCE_W   = 32
);
    logic                         start;
    logic                         abort;
    logic [NONCE_W-1:0]           start_nonce;
    logic [NONCE_W-1:0]           max_nonce;
    logic [NUM_LANES-1:0]         lane_ready;
    logic [NUM_LANES-1:0]         lane_done;
    logic [NUM_LANES-1:0]         lane_hit;
    logic [NUM_LANES-1:0]         lane_issue;
    logic [NUM_LANES*NONCE_W-1:0] lane_nonce;
    logic                         busy;
    logic                         finished;
    logic                         not_found;
    logic [NONCE_W-1:0]           nonce_out;

    modport master (
        output start, abort, start_nonce, max_nonce,
        output lane_ready, lane_done, lane_hit,
        input  lane_issue, lane_nonce,
        input  busy, finished, not_found, nonce_out
    );

    modport slave (
        input  start, abort, start_nonce, max_nonce,
        input  lane_ready, lane_done, lane_hit,
        output lane_issue, lane_nonce,
        output busy, finished, not_found, nonce_out
    );
endinterface

// File: rtl/nonce_dispatch_ctrl.sv
// Nonce search controller: issues one nonce per lane per round,
// collects lane results and reports the winner or exhaustion.
module nonce_dispatch_ctrl #(
    parameter int NUM_LANES = 3,
    parameter int NONCE_W   = 32
) (
    input logic                  clk,
    input logic                  reset,
    nonce_dispatch_ctrl_if.slave bus
);

    localparam int BW = NONCE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_EXHAUSTED
    } state_t;

    state_t                       state_q;
    logic [BW-1:0]                base_q;
    logic [NONCE_W-1:0]           limit_q;
    logic [NUM_LANES-1:0]         mask_q;
    logic [NUM_LANES-1:0]         lane_issue_q;
    logic [NUM_LANES*NONCE_W-1:0] lane_nonce_q;
    logic                         busy_q;
    logic                         finished_q;
    logic                         not_found_q;
    logic [NONCE_W-1:0]           nonce_out_q;

    logic [BW-1:0]        lane_val [NUM_LANES];
    logic [NUM_LANES-1:0] issue_mask;
    logic [NUM_LANES-1:0] done_v;
    logic [NUM_LANES-1:0] hit_v;
    logic [NUM_LANES-1:0] mask_d;
    logic [BW-1:0]        base_d;
    logic                 ready_ok;
    logic                 range_end;
    logic [NONCE_W-1:0]   win_nonce;

    // Extra base bit keeps base+i from wrapping at the top of the range
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_val[i]   = base_q + BW'(i);
            issue_mask[i] = lane_val[i] <= {1'b0, limit_q};
        end
        ready_ok  = (bus.lane_ready & issue_mask) == issue_mask;
        done_v    = bus.lane_done & mask_q;
        hit_v     = done_v & bus.lane_hit;
        mask_d    = mask_q & ~done_v;
        base_d    = base_q + BW'(NUM_LANES);
        range_end = base_d > {1'b0, limit_q};
        win_nonce = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                win_nonce = lane_nonce_q[i*NONCE_W +: NONCE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            limit_q      <= '0;
            mask_q       <= '0;
            lane_issue_q <= '0;
            lane_nonce_q <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            not_found_q  <= 1'b0;
            nonce_out_q  <= '0;
        end else begin
            lane_issue_q <= '0;
            if (bus.abort) begin
                state_q      <= S_IDLE;
                mask_q       <= '0;
                lane_nonce_q <= '0;
                busy_q       <= 1'b0;
                finished_q   <= 1'b0;
                not_found_q  <= 1'b0;
                nonce_out_q  <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_DONE, S_EXHAUSTED: begin
                        if (bus.start) begin
                            base_q      <= {1'b0, bus.start_nonce};
                            limit_q     <= bus.max_nonce;
                            nonce_out_q <= '0;
                            if (bus.start_nonce > bus.max_nonce) begin
                                state_q     <= S_EXHAUSTED;
                                busy_q      <= 1'b0;
                                finished_q  <= 1'b1;
                                not_found_q <= 1'b1;
                            end else begin
                                state_q     <= S_ISSUE;
                                busy_q      <= 1'b1;
                                finished_q  <= 1'b0;
                                not_found_q <= 1'b0;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (ready_ok) begin
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (issue_mask[i]) begin
                                    lane_nonce_q[i*NONCE_W +: NONCE_W] <=
                                        lane_val[i][NONCE_W-1:0];
                                end
                            end
                            lane_issue_q <= issue_mask;
                            mask_q       <= issue_mask;
                            state_q      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // A hit is checked before the emptied mask
                        if (|hit_v) begin
                            state_q     <= S_DONE;
                            mask_q      <= '0;
                            nonce_out_q <= win_nonce;
                            busy_q      <= 1'b0;
                            finished_q  <= 1'b1;
                            not_found_q <= 1'b0;
                        end else if (mask_d == '0) begin
                            mask_q <= '0;
                            if (range_end) begin
                                state_q     <= S_EXHAUSTED;
                                nonce_out_q <= '0;
                                busy_q      <= 1'b0;
                                finished_q  <= 1'b1;
                                not_found_q <= 1'b1;
                            end else begin
                                base_q  <= base_d;
                                state_q <= S_ISSUE;
                            end
                        end else begin
                            mask_q <= mask_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.lane_issue = lane_issue_q;
    assign bus.lane_nonce = lane_nonce_q;
    assign bus.busy       = busy_q;
    assign bus.finished   = finished_q;
    assign bus.not_found  = not_found_q;
    assign bus.nonce_out  = nonce_out_q;

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Directed-vector bench for nonce_dispatch_ctrl (3 lanes, 32-bit nonce).
module tb_nonce_dispatch_ctrl;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    nonce_dispatch_ctrl_if #(.NUM_LANES(3), .NONCE_W(32)) bus ();

    nonce_dispatch_ctrl #(.NUM_LANES(3), .NONCE_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] sn, input logic [31:0] mn);
        bus.start       = 1'b1;
        bus.start_nonce = sn;
        bus.max_nonce   = mn;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic result(input logic [2:0] d, input logic [2:0] h);
        bus.lane_done = d;
        bus.lane_hit  = h;
        tick();
        bus.lane_done = '0;
        bus.lane_hit  = '0;
    endtask

    logic [2:0] seen;

    initial begin
        nvec = 0;
        nerr = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.start_nonce = '0;
        bus.max_nonce   = '0;
        bus.lane_ready  = 3'b111;
        bus.lane_done   = '0;
        bus.lane_hit    = '0;
        tick();
        tick();
        chk("rst_busy", 96'(bus.busy), 96'd0);
        chk("rst_fin", 96'(bus.finished), 96'd0);
        chk("rst_nf", 96'(bus.not_found), 96'd0);
        chk("rst_nout", 96'(bus.nonce_out), 96'd0);
        chk("rst_issue", 96'(bus.lane_issue), 96'd0);
        chk("rst_lnonce", bus.lane_nonce, 96'd0);
        reset = 1'b0;
        tick();

        // single hit in round 0, lane 1
        launch(32'd0, 32'd100);
        chk("sh_busy", 96'(bus.busy), 96'd1);
        chk("sh_noissue", 96'(bus.lane_issue), 96'd0);
        tick();
        chk("sh_issue", 96'(bus.lane_issue), 96'b111);
        chk("sh_lnonce", bus.lane_nonce, {32'd2, 32'd1, 32'd0});
        result(3'b111, 3'b010);
        chk("sh_fin", 96'(bus.finished), 96'd1);
        chk("sh_nout", 96'(bus.nonce_out), 96'd1);
        chk("sh_nf", 96'(bus.not_found), 96'd0);
        chk("sh_busy0", 96'(bus.busy), 96'd0);

        // simultaneous hits in round 2; restart from DONE
        launch(32'd0, 32'd100);
        chk("sim_findrop", 96'(bus.finished), 96'd0);
        chk("sim_busy", 96'(bus.busy), 96'd1);
        tick();
        chk("sim_r0", bus.lane_nonce, {32'd2, 32'd1, 32'd0});
        result(3'b111, 3'b000);
        tick();
        chk("sim_r1", bus.lane_nonce, {32'd5, 32'd4, 32'd3});
        chk("sim_r1iss", 96'(bus.lane_issue), 96'b111);
        result(3'b111, 3'b000);
        tick();
        chk("sim_r2", bus.lane_nonce, {32'd8, 32'd7, 32'd6});
        result(3'b101, 3'b101);
        chk("sim_fin", 96'(bus.finished), 96'd1);
        chk("sim_nout", 96'(bus.nonce_out), 96'd6);
        result(3'b110, 3'b110);
        chk("late_nout", 96'(bus.nonce_out), 96'd6);
        chk("late_fin", 96'(bus.finished), 96'd1);

        // exhaustion with a partial second round
        launch(32'd0, 32'd4);
        tick();
        chk("ex_r0iss", 96'(bus.lane_issue), 96'b111);
        result(3'b111, 3'b000);
        tick();
        chk("ex_r1iss", 96'(bus.lane_issue), 96'b011);
        chk("ex_r1", bus.lane_nonce, {32'd2, 32'd4, 32'd3});
        result(3'b011, 3'b000);
        chk("ex_fin", 96'(bus.finished), 96'd1);
        chk("ex_nf", 96'(bus.not_found), 96'd1);
        chk("ex_nout", 96'(bus.nonce_out), 96'd0);
        chk("ex_busy", 96'(bus.busy), 96'd0);

        // top of range: no wrap to nonce 0
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        tick();
        chk("top_iss", 96'(bus.lane_issue), 96'b011);
        chk("top_l0", 96'(bus.lane_nonce[31:0]), 96'hFFFF_FFFE);
        chk("top_l1", 96'(bus.lane_nonce[63:32]), 96'hFFFF_FFFF);
        result(3'b011, 3'b000);
        seen = bus.lane_issue;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | bus.lane_issue;
        end
        chk("top_noissue", 96'(seen), 96'd0);
        chk("top_nf", 96'(bus.not_found), 96'd1);
        chk("top_fin", 96'(bus.finished), 96'd1);

        // empty range goes straight to exhaustion
        launch(32'd10, 32'd5);
        chk("empty_nf", 96'(bus.not_found), 96'd1);
        chk("empty_busy", 96'(bus.busy), 96'd0);

        // backpressure on lane 1, start while busy, hit on lane 2
        bus.lane_ready = 3'b101;
        launch(32'd0, 32'd100);
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | bus.lane_issue;
        end
        chk("bp_hold", 96'(seen), 96'd0);
        chk("bp_busy", 96'(bus.busy), 96'd1);
        bus.lane_ready = 3'b111;
        tick();
        chk("bp_iss", 96'(bus.lane_issue), 96'b111);
        launch(32'd50, 32'd60);
        chk("busy_start", bus.lane_nonce, {32'd2, 32'd1, 32'd0});
        result(3'b111, 3'b100);
        chk("bp_nout", 96'(bus.nonce_out), 96'd2);

        // abort beats a hit on the same edge
        launch(32'd0, 32'd100);
        tick();
        bus.abort = 1'b1;
        result(3'b111, 3'b001);
        bus.abort = 1'b0;
        chk("ab_fin", 96'(bus.finished), 96'd0);
        chk("ab_busy", 96'(bus.busy), 96'd0);
        chk("ab_nout", 96'(bus.nonce_out), 96'd0);
        chk("ab_lnonce", bus.lane_nonce, 96'd0);

        // reset in WAIT clears outputs at once
        launch(32'd0, 32'd100);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mr_busy", 96'(bus.busy), 96'd0);
        chk("mr_lnonce", bus.lane_nonce, 96'd0);
        tick();
        reset = 1'b0;
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | bus.lane_issue;
        end
        chk("mr_noissue", 96'(seen), 96'd0);
        chk("mr_idle", 96'(bus.busy), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
